vga_sync_timer: RTL and testbench
=================================

# vga_sync_timer

Free-running VGA raster timing core for the TinyVGA PMOD pixel path. It produces horizontal/vertical sync, the display-active window, and current pixel coordinates for the pattern/animation logic downstream. It also supplies single-cycle raster event strobes (line start, frame start, vertical-blank start) and a frame counter, so downstream motion logic can run on the main clock instead of clocking off vsync. It clocks directly from the pixel clock (25.175 MHz nominal, one pixel per cycle).

## Interface

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_POL, 0, active sync level (0 = active-low, 1 = active-high)

Ports:
- clk  in  1  pixel clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- hsync  out  1  horizontal sync, active level = SYNC_POL
- vsync  out  1  vertical sync, active level = SYNC_POL
- display_on  out  1  high when (hpos, vpos) lies in the visible area
- hpos  out  10  current column, 0..H_TOTAL-1
- vpos  out  10  current line, 0..V_TOTAL-1
- line_start  out  1  one-cycle strobe at hpos==0
- frame_start  out  1  one-cycle strobe at hpos==0 && vpos==0
- vblank_start  out  1  one-cycle strobe at hpos==0 && vpos==V_DISPLAY
- frame_count  out  8  completed-frame counter, wraps 255->0

## Operation

- Constants: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- hpos increments every cycle. At H_TOTAL-1, hpos wraps to 0 and vpos increments. At vpos==V_TOTAL-1 with hpos==H_TOTAL-1, vpos wraps to 0.
- frame_count increments on the same edge that wraps (H_TOTAL-1, V_TOTAL-1) to (0,0), modulo 256.
- hsync is active iff H_DISPLAY+H_FRONT <= hpos <= H_DISPLAY+H_FRONT+H_SYNC-1 (656..751 by default).
- vsync is active iff V_DISPLAY+V_FRONT <= vpos <= V_DISPLAY+V_FRONT+V_SYNC-1 (490..491). vsync spans whole lines, asserting and deasserting at hpos==0.
- display_on = (hpos < H_DISPLAY) && (vpos < V_DISPLAY).
- Strobes follow the coordinate conditions listed in Interface. Where conditions coincide, strobes are independent: at (0,0), line_start and frame_start are both high.
- All comparisons are unsigned, 10-bit. Parameter sets with H_TOTAL or V_TOTAL > 1024 are unsupported.
- Reset (synchronous, dominates): hpos=0, vpos=0, frame_count=0. While reset is high, display_on and all strobes are forced 0 and hsync/vsync sit at the inactive level (~SYNC_POL).
- Reset asserted mid-frame aborts the frame. The counters return to (0,0) on the next edge with no partial-frame count.

## Timing

- hpos, vpos, frame_count: registers.
- hsync, vsync, display_on, strobes: zero-latency decode of the current hpos/vpos registers, gated by reset. No pipeline offset exists between the coordinates and the decoded outputs. Any consumer that registers pixel colour must delay hsync/vsync to match.
- First cycle after reset deasserts: hpos=0, vpos=0, display_on=1, line_start=1, frame_start=1, vblank_start=0.
- Line period 800 cycles, hsync width 96 cycles; frame period 420000 cycles; vsync width 1600 cycles.
- Strobes are exactly 1 cycle wide and never back-to-back.

## Test plan

- Hold reset 5 cycles (SYNC_POL=0) -> hpos=vpos=0, hsync=vsync=1, display_on=0, all strobes 0, frame_count=0. Release -> first cycle display_on=1, line_start=1, frame_start=1.
- Run one line -> display_on=1 at hpos 639 and 0 at hpos 640. hsync low for hpos 656..751 (exactly 96 cycles). hpos 799 -> 0 with vpos 0 -> 1; line_start every 800 cycles.
- Run one frame -> vblank_start at (0,480) only. vsync low from (0,490) through (799,491), 1600 cycles. display_on never high for vpos>=480. vpos 524 -> 0.
- Run 257 frames -> frame_start spacing exactly 420000 cycles. frame_count reads 255 after 255 wraps and returns to 0 on the 256th wrap, reaching 1 on the 257th.
- Assert reset for 1 cycle at (300,200) with frame_count=7 -> next cycle hpos=0, vpos=0, frame_count=0, syncs inactive. After release, timing restarts as in the first scenario.
- SYNC_POL=1 -> hsync/vsync idle low and pulse high over the same hpos/vpos windows; all other outputs identical to the SYNC_POL=0 run.

Source files
------------

// File: rtl/vga_sync_timer_if.sv
// Raster timing bundle: syncs, visible window, coordinates, event strobes, frame count.
// The timer drives it through the master modport; pattern/animation logic reads it through the slave modport.
interface vga_sync_timer_if;
    logic       hsync;
    logic       vsync;
    logic       display_on;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       line_start;
    logic       frame_start;
    logic       vblank_start;
    logic [7:0] frame_count;

    modport master (
        output hsync, vsync, display_on, hpos, vpos,
               line_start, frame_start, vblank_start, frame_count
    );

    modport slave (
        input  hsync, vsync, display_on, hpos, vpos,
               line_start, frame_start, vblank_start, frame_count
    );
endinterface

// File: rtl/vga_sync_timer.sv
// Free-running VGA raster timer: hpos/vpos/frame_count are registers, everything else decodes them combinationally.
// Zero latency between coordinates and decoded outputs; no backpressure, the raster never stalls.
module vga_sync_timer #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    vga_sync_timer_if.master vga
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [9:0] hpos_q;
    logic [9:0] vpos_q;
    logic [7:0] frame_count_q;

    logic h_wrap;
    logic v_wrap;
    logic hsync_act;
    logic vsync_act;

    assign h_wrap = (hpos_q == H_LAST);
    assign v_wrap = (vpos_q == V_LAST);

    // A mid-frame reset discards the partial frame: no count is credited for it.
    always_ff @(posedge clk) begin
        if (reset) begin
            hpos_q        <= '0;
            vpos_q        <= '0;
            frame_count_q <= '0;
        end else if (h_wrap) begin
            hpos_q <= '0;
            if (v_wrap) begin
                vpos_q        <= '0;
                frame_count_q <= frame_count_q + 8'd1;
            end else begin
                vpos_q <= vpos_q + 10'd1;
            end
        end else begin
            hpos_q <= hpos_q + 10'd1;
        end
    end

    // vsync depends on vpos only, so it spans whole lines and toggles at hpos==0.
    assign hsync_act = (hpos_q >= HS_FIRST) && (hpos_q <= HS_LAST);
    assign vsync_act = (vpos_q >= VS_FIRST) && (vpos_q <= VS_LAST);

    assign vga.hpos        = hpos_q;
    assign vga.vpos        = vpos_q;
    assign vga.frame_count = frame_count_q;

    assign vga.hsync        = (hsync_act && !reset) ? SYNC_POL : ~SYNC_POL;
    assign vga.vsync        = (vsync_act && !reset) ? SYNC_POL : ~SYNC_POL;
    assign vga.display_on   = !reset && (hpos_q < H_VIS) && (vpos_q < V_VIS);
    assign vga.line_start   = !reset && (hpos_q == 10'd0);
    assign vga.frame_start  = !reset && (hpos_q == 10'd0) && (vpos_q == 10'd0);
    assign vga.vblank_start = !reset && (hpos_q == 10'd0) && (vpos_q == V_VIS);

endmodule

// File: tb/tb_vga_sync_timer.sv
// Bench for vga_sync_timer: two reduced-geometry instances (both sync polarities) plus one default-geometry instance.
module tb_vga_sync_timer;

    // Reduced raster: 15 x 10 = 150 cycles per frame keeps 257 frames short.
    localparam int HD = 8, HF = 2, HS = 3, HB = 2;
    localparam int VD = 6, VF = 1, VS = 2, VB = 1;
    localparam int FR = (HD + HF + HS + HB) * (VD + VF + VS + VB);

    logic clk;
    logic reset;
    bit   chk_en;
    int   n;
    int   total;
    int   bad;

    vga_sync_timer_if bus0 ();
    vga_sync_timer_if bus1 ();
    vga_sync_timer_if bus2 ();

    vga_sync_timer #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(1'b0)
    ) dut0 (.clk(clk), .reset(reset), .vga(bus0));

    vga_sync_timer #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(1'b1)
    ) dut1 (.clk(clk), .reset(reset), .vga(bus1));

    vga_sync_timer dut2 (.clk(clk), .reset(reset), .vga(bus2));

    logic [33:0] v0, v1, v2;
    assign v0 = {bus0.hsync, bus0.vsync, bus0.display_on, bus0.hpos, bus0.vpos,
                 bus0.line_start, bus0.frame_start, bus0.vblank_start, bus0.frame_count};
    assign v1 = {bus1.hsync, bus1.vsync, bus1.display_on, bus1.hpos, bus1.vpos,
                 bus1.line_start, bus1.frame_start, bus1.vblank_start, bus1.frame_count};
    assign v2 = {bus2.hsync, bus2.vsync, bus2.display_on, bus2.hpos, bus2.vpos,
                 bus2.line_start, bus2.frame_start, bus2.vblank_start, bus2.frame_count};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles elapsed since the last edge that sampled reset high.
    always @(posedge clk) begin
        if (reset) n = 0;
        else       n = n + 1;
    end

    // Raster position is pure arithmetic on elapsed cycles; outputs follow from the timing windows.
    function automatic logic [33:0] model(int cyc, bit rst, int hd, int hf, int hs, int hb,
                                          int vd, int vf, int vs, int vb, bit pol);
        int ht, vt, h, v, f;
        bit hact, vact, de, ls, fs, vbs, hsy, vsy;
        ht   = hd + hf + hs + hb;
        vt   = vd + vf + vs + vb;
        h    = cyc % ht;
        v    = (cyc / ht) % vt;
        f    = (cyc / (ht * vt)) % 256;
        hact = (h >= hd + hf) && (h <= hd + hf + hs - 1);
        vact = (v >= vd + vf) && (v <= vd + vf + vs - 1);
        hsy  = (!rst && hact) ? pol : !pol;
        vsy  = (!rst && vact) ? pol : !pol;
        de   = !rst && (h < hd) && (v < vd);
        ls   = !rst && (h == 0);
        fs   = ls && (v == 0);
        vbs  = ls && (v == vd);
        return {hsy, vsy, de, 10'(h), 10'(v), ls, fs, vbs, 8'(f)};
    endfunction

    task automatic check(string name, logic [63:0] got, logic [63:0] want);
        total = total + 1;
        if (got !== want) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cycle_pol0",    64'(v0), 64'(model(n, reset, HD, HF, HS, HB, VD, VF, VS, VB, 1'b0)));
            check("cycle_pol1",    64'(v1), 64'(model(n, reset, HD, HF, HS, HB, VD, VF, VS, VB, 1'b1)));
            check("cycle_default", 64'(v2), 64'(model(n, reset, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int hl2, ls2, vl0, vb0, vbn, hh1, fs0, last_fs, nfs;

    initial begin
        reset   = 1'b1;
        chk_en  = 1'b0;
        n       = 0;
        total   = 0;
        bad     = 0;
        tick();
        chk_en = 1'b1;
        repeat (4) tick();

        check("reset_state_pol0", 64'(v0), 64'({1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 3'b000, 8'd0}));
        check("reset_state_pol1", 64'(v1), 64'({1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 3'b000, 8'd0}));
        check("reset_state_default", 64'(v2), 64'({1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 3'b000, 8'd0}));

        reset = 1'b0;
        #1;
        check("first_cycle_pol0", 64'({bus0.display_on, bus0.line_start, bus0.frame_start, bus0.vblank_start}), 64'(4'b1110));
        check("first_cycle_default", 64'({bus2.display_on, bus2.line_start, bus2.frame_start, bus2.vblank_start}), 64'(4'b1110));

        hl2 = 0; ls2 = 0; vl0 = 0; vb0 = 0; vbn = -1; hh1 = 0; fs0 = 0;
        for (int k = 0; k < 1099; k++) begin
            if (k < 800 && !bus2.hsync) hl2++;
            if (bus2.line_start) ls2++;
            if (k < FR && !bus0.vsync) vl0++;
            if (k < FR && bus0.vblank_start) begin vb0++; vbn = k; end
            if (k < 15 && bus1.hsync) hh1++;
            if (bus0.frame_start) fs0++;
            if (k == 639) check("display_on_hpos639", 64'(bus2.display_on), 64'(1));
            if (k == 640) check("display_on_hpos640", 64'(bus2.display_on), 64'(0));
            if (k == 799) check("line_end_default", 64'({bus2.hpos, bus2.vpos}), 64'({10'd799, 10'd0}));
            if (k == 800) check("line_wrap_default", 64'({bus2.hpos, bus2.vpos}), 64'({10'd0, 10'd1}));
            if (k == 149) check("frame_end_pol0", 64'({bus0.hpos, bus0.vpos, bus0.frame_count}), 64'({10'd14, 10'd9, 8'd0}));
            if (k == 150) check("frame_wrap_pol0", 64'({bus0.hpos, bus0.vpos, bus0.frame_count}), 64'({10'd0, 10'd0, 8'd1}));
            tick();
        end
        check("hsync_width_default", 64'(hl2), 64'(96));
        check("line_start_count_default", 64'(ls2), 64'(2));
        check("vsync_width_pol0", 64'(vl0), 64'(30));
        check("vblank_count_pol0", 64'(vb0), 64'(1));
        check("vblank_position_pol0", 64'(vbn), 64'(90));
        check("hsync_high_width_pol1", 64'(hh1), 64'(3));
        check("frame_start_count_pol0", 64'(fs0), 64'(8));

        check("midframe_position", 64'({bus0.hpos, bus0.vpos, bus0.frame_count}), 64'({10'd4, 10'd3, 8'd7}));
        reset = 1'b1;
        tick();
        check("midframe_reset_pol0", 64'({bus0.hpos, bus0.vpos, bus0.frame_count, bus0.hsync, bus0.vsync}),
              64'({10'd0, 10'd0, 8'd0, 1'b1, 1'b1}));
        check("midframe_reset_pol1_syncs", 64'({bus1.hsync, bus1.vsync}), 64'(2'b00));
        reset = 1'b0;
        #1;
        check("restart_first_cycle_pol0", 64'({bus0.display_on, bus0.line_start, bus0.frame_start, bus0.vblank_start}), 64'(4'b1110));

        last_fs = -1;
        nfs     = 0;
        for (int k = 0; k <= 257 * FR; k++) begin
            if (bus0.frame_start) begin
                nfs++;
                if (last_fs >= 0) check("frame_spacing_pol0", 64'(k - last_fs), 64'(FR));
                last_fs = k;
            end
            if (k == 255 * FR - 1) check("frame_count_254", 64'(bus0.frame_count), 64'(254));
            if (k == 255 * FR)     check("frame_count_255", 64'(bus0.frame_count), 64'(255));
            if (k == 256 * FR)     check("frame_count_wrap0", 64'(bus0.frame_count), 64'(0));
            if (k == 257 * FR)     check("frame_count_1", 64'({bus0.frame_count, bus1.frame_count}), 64'({8'd1, 8'd1}));
            tick();
        end
        check("frame_start_total_pol0", 64'(nfs), 64'(258));

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
